// File: rtl/regfile_pkg.sv
// regfile_pkg: default register-file geometry and shared helpers for flat-bus slicing and address qualification.
package regfile_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;
  function automatic int lsb(int port, int width);
    return port * width;
  endfunction
  function automatic logic in_file(int addr, int num_regs, int zero_reg);
    return addr < num_regs && addr != zero_reg;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits; issue-set beats flush-clear beats write-clear.
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic                            issue_en,
  input  logic [ADDR_WIDTH-1:0]           issue_addr,
  input  logic                            flush,
  output logic [NUM_REGS-1:0]             pending
);
  import regfile_pkg::*;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [ADDR_WIDTH-1:0] wa [NUM_WRITE];
  for (genvar p = 0; p < NUM_WRITE; p++) begin : g_wa
    assign wa[p] = wr_addr[lsb(p, ADDR_WIDTH) +: ADDR_WIDTH];
  end
  always_comb begin
    pend_nxt = pending;
    for (int p = 0; p < NUM_WRITE; p++)
      if (wr_en[p] && in_file(int'(wa[p]), NUM_REGS, ZERO_REG)) pend_nxt[wa[p]] = 1'b0;
    if (flush) pend_nxt = '0;
    if (issue_en && in_file(int'(issue_addr), NUM_REGS, ZERO_REG)) pend_nxt[issue_addr] = 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) pending <= '0;
    else pending <= pend_nxt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with hardwired XZR, same-cycle write bypass and a pending scoreboard.
module regfile_sb #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int NUM_READ = 2,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG,
  parameter bit BYPASS = 1'b1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]             rd_ready,
  input  logic                            issue_en,
  input  logic [ADDR_WIDTH-1:0]           issue_addr,
  input  logic                            flush,
  output logic [NUM_REGS-1:0]             pending
);
  import regfile_pkg::*;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [ADDR_WIDTH-1:0] wa [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wd [NUM_WRITE];
  logic [NUM_WRITE-1:0] we;
  for (genvar p = 0; p < NUM_WRITE; p++) begin : g_wr
    assign wa[p] = wr_addr[lsb(p, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wd[p] = wr_data[lsb(p, DATA_WIDTH) +: DATA_WIDTH];
    assign we[p] = wr_en[p] && in_file(int'(wa[p]), NUM_REGS, ZERO_REG);
  end
  // Ascending port order makes the highest-index writer win a collision.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else for (int p = 0; p < NUM_WRITE; p++) if (we[p]) mem[wa[p]] <= wd[p];
  regfile_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS(NUM_REGS),
    .NUM_WRITE(NUM_WRITE),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clock(clock),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .issue_en(issue_en),
    .issue_addr(issue_addr),
    .flush(flush),
    .pending(pending)
  );
  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    logic v;
    logic ok;
    assign a = rd_addr[lsb(r, ADDR_WIDTH) +: ADDR_WIDTH];
    assign ok = in_file(int'(a), NUM_REGS, ZERO_REG);
    always_comb begin
      d = ok ? mem[a] : '0;
      v = ok ? !pending[a] : 1'b1;
      for (int p = 0; p < NUM_WRITE; p++)
        if (BYPASS && we[p] && wa[p] == a) begin
          d = wd[p];
          v = 1'b1;
        end
    end
    // Reset forces a clean view even if a bypassable write is presented.
    assign rd_data[lsb(r, DATA_WIDTH) +: DATA_WIDTH] = reset_n ? d : '0;
    assign rd_ready[r] = v || !reset_n;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scenario tasks push expected reads/pending into a scoreboard queue and compare against the DUT.
module tb_regfile_sb;
  localparam int DW = 64;
  localparam int AW = 5;
  logic clock = 1'b0;
  logic reset_n;
  logic [1:0] wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0] rd_ready;
  logic issue_en;
  logic [AW-1:0] issue_addr;
  logic flush;
  logic [31:0] pending;
  typedef struct {
    string name;
    bit is_pend;
    int port;
    logic [DW-1:0] data;
    logic ready;
    logic [31:0] pend;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [DW-1:0] ad;
  logic ar;
  int vecs = 0;
  int miss = 0;

  regfile_sb dut (
    .clock(clock),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_ready(rd_ready),
    .issue_en(issue_en),
    .issue_addr(issue_addr),
    .flush(flush),
    .pending(pending)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic idle();
    wr_en = '0;
    issue_en = 1'b0;
    flush = 1'b0;
  endtask
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask
  task automatic wr(int p, int a, logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask
  task automatic rd(int p, int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask
  task automatic issue(int a);
    issue_en = 1'b1;
    issue_addr = AW'(a);
  endtask
  task automatic push_rd(string n, int p, logic [DW-1:0] d, logic r);
    sb.push_back('{name: n, is_pend: 1'b0, port: p, data: d, ready: r, pend: '0});
  endtask
  task automatic push_pend(string n, logic [31:0] v);
    sb.push_back('{name: n, is_pend: 1'b1, port: 0, data: '0, ready: 1'b0, pend: v});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    issue_addr = '0;
    @(negedge clock);
    reset_n = 1'b1;
    wr(0, 7, 64'hDEAD);
    issue(8);
    tick();
    rd(0, 7);
    rd(1, 8);
    push_rd("pre_reset_r7", 0, 64'hDEAD, 1'b1);
    push_rd("pre_reset_r8", 1, 64'h0, 1'b0);
    push_pend("pre_reset_pend", 32'h100);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    reset_n = 1'b0;
    wr(1, 7, 64'h1234);
    push_rd("reset_r7", 0, 64'h0, 1'b1);
    push_rd("reset_r8", 1, 64'h0, 1'b1);
    push_pend("reset_pend", 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_collision();
    wr(0, 5, 64'h11);
    wr(1, 5, 64'h22);
    rd(0, 5);
    push_rd("collide_bypass", 0, 64'h22, 1'b1);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    rd(1, 5);
    push_rd("collide_p0", 0, 64'h22, 1'b1);
    push_rd("collide_p1", 1, 64'h22, 1'b1);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
  endtask

  task automatic test_zero_reg();
    wr(0, 31, 64'hFFFF);
    rd(1, 31);
    push_rd("xzr_no_bypass", 1, 64'h0, 1'b1);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    issue(31);
    rd(0, 31);
    push_rd("xzr_read", 0, 64'h0, 1'b1);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    push_pend("xzr_issue_pend", 32'h0);
    push_rd("xzr_after_issue", 0, 64'h0, 1'b1);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
  endtask

  task automatic test_issue_write();
    issue(3);
    tick();
    rd(0, 3);
    push_rd("r3_stalled", 0, 64'h0, 1'b0);
    push_pend("r3_pend_set", 32'h8);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    wr(1, 3, 64'h7);
    push_rd("r3_bypass_ready", 0, 64'h7, 1'b1);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    push_rd("r3_written", 0, 64'h7, 1'b1);
    push_pend("r3_pend_clear", 32'h0);
    issue(4);
    wr(0, 4, 64'h9);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    rd(0, 4);
    push_rd("r4_issue_wins", 0, 64'h9, 1'b0);
    push_pend("r4_pend", 32'h10);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
  endtask

  task automatic test_flush();
    issue(1);
    tick();
    issue(2);
    tick();
    push_pend("pend_124", 32'h16);
    flush = 1'b1;
    issue(6);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    rd(0, 1);
    rd(1, 6);
    push_pend("flush_issue", 32'h40);
    push_rd("flushed_r1", 0, 64'h0, 1'b1);
    push_rd("issued_r6", 1, 64'h0, 1'b0);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v [8];
    for (int i = 0; i < 8; i++) begin
      v[i] = {$urandom, $urandom};
      wr(i % 2, 8 + i, v[i]);
      rd(1, 8 + i);
      push_rd($sformatf("b2b_bypass_%0d", i), 1, v[i], 1'b1);
      if (i > 0) begin
        rd(0, 7 + i);
        push_rd($sformatf("b2b_prev_%0d", i), 0, v[i-1], 1'b1);
      end
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vecs++;
        ad = rd_data[e.port*DW +: DW];
        ar = rd_ready[e.port];
        if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
          miss++;
          $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_write();
    wr(0, 9, 64'hAB);
    rd(0, 9);
    rd(1, 6);
    #2;
    reset_n = 1'b0;
    push_rd("midrst_r9", 0, 64'h0, 1'b1);
    push_rd("midrst_r6", 1, 64'h0, 1'b1);
    push_pend("midrst_pend", 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
    tick();
    reset_n = 1'b1;
    rd(1, 5);
    push_rd("post_rst_r9", 0, 64'h0, 1'b1);
    push_rd("post_rst_r5", 1, 64'h0, 1'b1);
    push_pend("post_rst_pend", 32'h0);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vecs++;
      ad = rd_data[e.port*DW +: DW];
      ar = rd_ready[e.port];
      if (e.is_pend ? (pending !== e.pend) : (ad !== e.data || ar !== e.ready)) begin
        miss++;
        $display("FAIL %s: got data=%h ready=%b pend=%h, want data=%h ready=%b pend=%h", e.name, ad, ar, pending, e.data, e.ready, e.pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_zero_reg();
    test_issue_write();
    test_flush();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
